// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding controller beside decode: a shift-register scoreboard of in-flight
// register writes (EX..WB) drives the stall and per-operand forward selects.
module pipe_scoreboard #(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned DEPTH     = 3,
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          RF_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FSEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rd_rs,
  input  logic              id_rd_rt,
  input  logic              id_regwrite,
  input  logic [REG_W-1:0]  id_wreg,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [FSEL_W-1:0] fwd_a,
  output logic [FSEL_W-1:0] fwd_b,
  output logic              sb_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0][REG_W-1:0] wreg_q;
  logic [DEPTH-1:0]            ld_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [FSEL_W:0] res_a, res_b;
  logic            haz_a, haz_b, issue;

  // Returns {hazard, fwd}. Scanning from WB down to EX leaves the youngest producer selected.
  function automatic logic [FSEL_W:0] resolve(
    input logic [REG_W-1:0]            src,
    input logic                        rd_en,
    input logic [DEPTH-1:0]            v,
    input logic [DEPTH-1:0][REG_W-1:0] wreg,
    input logic [DEPTH-1:0]            ld
  );
    logic              hit;
    logic              ld_hit;
    logic              haz;
    logic [FSEL_W-1:0] sel;
    hit    = 1'b0;
    ld_hit = 1'b0;
    haz    = 1'b0;
    sel    = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (rd_en && v[i] && (wreg[i] == src)) begin
        hit    = 1'b1;
        ld_hit = ld[i];
        sel    = FSEL_W'(i + 1);
      end
    end
    if (FWD_EN) begin
      // Only a load still in EX cannot be forwarded yet.
      haz = hit && ld_hit && (sel == FSEL_W'(1));
    end else begin
      haz = hit && ((sel != FSEL_W'(DEPTH)) || !RF_BYPASS);
      sel = '0;
    end
    return {haz, sel};
  endfunction

  always_comb begin
    res_a   = resolve(id_rs, id_rd_rs, v_q, wreg_q, ld_q);
    res_b   = resolve(id_rt, id_rd_rt, v_q, wreg_q, ld_q);
    haz_a   = res_a[FSEL_W];
    haz_b   = res_b[FSEL_W];
    fwd_a   = res_a[FSEL_W-1:0];
    fwd_b   = res_b[FSEL_W-1:0];
    stall   = id_valid && !flush && (haz_a || haz_b);
    issue   = id_valid && !stall && !flush;
    sb_busy = |v_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      wreg_q <= '0;
      ld_q   <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= {v_q[DEPTH-2:0], issue && id_regwrite};
      wreg_q <= {wreg_q[DEPTH-2:0], id_wreg};
      ld_q   <= {ld_q[DEPTH-2:0], id_is_load};
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench for pipe_scoreboard: four parameter variants share one stimulus stream,
// expectations are queued per cycle and compared against the selected instance.
module tb_pipe_scoreboard;

  localparam int SelStall = 0;
  localparam int SelFa    = 1;
  localparam int SelFb    = 2;
  localparam int SelBusy  = 3;
  localparam int SelCnt   = 4;

  typedef struct {
    string tag;
    int    dut;
    int    sel;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rd_rs, id_rd_rt, id_regwrite, id_is_load, flush;
  logic [2:0] id_rs, id_rt, id_wreg;

  logic        stall_w [4];
  logic [1:0]  fa_w    [4];
  logic [1:0]  fb_w    [4];
  logic        busy_w  [4];
  logic [15:0] cnt_w   [3];
  logic [1:0]  cnt_sat;

  always #5 clk = ~clk;

  // 0: defaults, 1: no forwarding with RF bypass, 2: no forwarding/no bypass, 3: 2-bit counter
  pipe_scoreboard u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd_rs(id_rd_rs), .id_rd_rt(id_rd_rt), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_w[0]), .fwd_a(fa_w[0]),
    .fwd_b(fb_w[0]), .sb_busy(busy_w[0]), .stall_cnt(cnt_w[0])
  );

  pipe_scoreboard #(.FWD_EN(1'b0), .RF_BYPASS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd_rs(id_rd_rs), .id_rd_rt(id_rd_rt), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_w[1]), .fwd_a(fa_w[1]),
    .fwd_b(fb_w[1]), .sb_busy(busy_w[1]), .stall_cnt(cnt_w[1])
  );

  pipe_scoreboard #(.FWD_EN(1'b0), .RF_BYPASS(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd_rs(id_rd_rs), .id_rd_rt(id_rd_rt), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_w[2]), .fwd_a(fa_w[2]),
    .fwd_b(fb_w[2]), .sb_busy(busy_w[2]), .stall_cnt(cnt_w[2])
  );

  pipe_scoreboard #(.CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd_rs(id_rd_rs), .id_rd_rt(id_rd_rt), .id_regwrite(id_regwrite), .id_wreg(id_wreg),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_w[3]), .fwd_a(fa_w[3]),
    .fwd_b(fb_w[3]), .sb_busy(busy_w[3]), .stall_cnt(cnt_sat)
  );

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int observe(input int dut, input int sel);
    case (sel)
      SelStall: return int'(stall_w[dut]);
      SelFa:    return int'(fa_w[dut]);
      SelFb:    return int'(fb_w[dut]);
      SelBusy:  return int'(busy_w[dut]);
      default:  return (dut == 3) ? int'(cnt_sat) : int'(cnt_w[dut]);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int dut, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.dut = dut;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                           input logic rrs, input logic rrt, input logic rw,
                           input logic [2:0] wr, input logic ld, input logic fl);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rd_rs    = rrs;
    id_rd_rt    = rrt;
    id_regwrite = rw;
    id_wreg     = wr;
    id_is_load  = ld;
    flush       = fl;
  endtask

  // Compare everything queued for this cycle mid-cycle, then move to just after the next edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.dut, e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_instr(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_instr(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with an active reader presented to every variant
    set_instr(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    for (int d = 0; d < 4; d++) begin
      expect_val($sformatf("rst_stall%0d", d), d, SelStall, 0);
      expect_val($sformatf("rst_fa%0d", d), d, SelFa, 0);
      expect_val($sformatf("rst_fb%0d", d), d, SelFb, 0);
      expect_val($sformatf("rst_busy%0d", d), d, SelBusy, 0);
      expect_val($sformatf("rst_cnt%0d", d), d, SelCnt, 0);
    end
    cycle();

    // ALU write R1, readers in the four following cycles
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    expect_val("alu_w_stall", 0, SelStall, 0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      set_instr(1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_val($sformatf("alu_fa_c%0d", k), 0, SelFa, (k < 4) ? k : 0);
      expect_val($sformatf("alu_stall_c%0d", k), 0, SelStall, 0);
      expect_val($sformatf("alu_busy_c%0d", k), 0, SelBusy, (k < 4) ? 1 : 0);
      cycle();
    end

    // Load-use on rt: one stall, then forward from MEM
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_val("lu_stall_c1", 0, SelStall, 1);
    cycle();
    expect_val("lu_stall_c2", 0, SelStall, 0);
    expect_val("lu_fb_c2", 0, SelFb, 2);
    expect_val("lu_cnt_c2", 0, SelCnt, 1);
    cycle();

    // Two writers of R3; youngest wins, including a self-overwriting reader
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    cycle();
    cycle();
    set_instr(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    expect_val("yng_fa", 0, SelFa, 1);
    expect_val("yng_fb", 0, SelFb, 1);
    expect_val("yng_stall", 0, SelStall, 0);
    cycle();
    set_instr(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_val("self_fa", 0, SelFa, 1);
    cycle();

    // No forwarding: stall until the write reaches WB (bypass) or retires (no bypass)
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      set_instr(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      expect_val($sformatf("nf_byp_stall_c%0d", k), 1, SelStall, (k <= 2) ? 1 : 0);
      expect_val($sformatf("nf_nobyp_stall_c%0d", k), 2, SelStall, (k <= 3) ? 1 : 0);
      if (k == 1) expect_val("fwd_ex_fa_c1", 0, SelFa, 1);
      if (k == 3) begin
        expect_val("nf_byp_fa_c3", 1, SelFa, 0);
        expect_val("nf_byp_cnt_c3", 1, SelCnt, 2);
      end
      if (k == 4) expect_val("nf_nobyp_cnt_c4", 2, SelCnt, 3);
      cycle();
    end

    // Flushed writer leaves nothing behind
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    expect_val("fl_stall_c0", 0, SelStall, 0);
    cycle();
    set_instr(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_val("fl_fa_c1", 0, SelFa, 0);
    expect_val("fl_stall_c1", 0, SelStall, 0);
    expect_val("fl_nobyp_stall_c1", 2, SelStall, 0);
    expect_val("fl_busy_c1", 0, SelBusy, 0);
    cycle();

    // Flush beats a load-use stall; the older load keeps shifting
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    expect_val("flpri_stall_c1", 0, SelStall, 0);
    cycle();
    set_instr(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_val("flpri_stall_c2", 0, SelStall, 0);
    expect_val("flpri_fa_c2", 0, SelFa, 2);
    expect_val("flpri_cnt_c2", 0, SelCnt, 0);
    cycle();

    // Reset in the middle of a load chain
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    cycle();
    set_instr(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    expect_val("mrst_stall_c1", 0, SelStall, 1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    expect_val("mrst_busy_c3", 0, SelBusy, 0);
    expect_val("mrst_stall_c3", 0, SelStall, 0);
    expect_val("mrst_cnt_c3", 0, SelCnt, 0);
    cycle();

    // Repeated load-use: stalls on odd cycles, narrow counter saturates at 3
    do_reset();
    set_instr(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    cycle();
    for (int k = 1; k <= 12; k++) begin
      set_instr(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
      expect_val($sformatf("sat_stall_c%0d", k), 3, SelStall, k % 2);
      expect_val($sformatf("sat_cnt_c%0d", k), 3, SelCnt, ((k / 2) < 3) ? (k / 2) : 3);
      expect_val($sformatf("wide_cnt_c%0d", k), 0, SelCnt, k / 2);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
